graytobin_seq: RTL and testbench
================================

Name: graytobin_seq

Overview:
Sequential Gray-to-binary decoder. It is the receive-side counterpart to the team's combinational binary-to-Gray encoder. It accepts one WIDTH-bit Gray code per valid/ready handshake and resolves it bit-serially, MSB to LSB, one bit per clock. It presents the binary result with a valid/ready output handshake, and flags any input that is not a single-bit step from the previously accepted code (Gray-counter integrity check for pointer/counter links).

Parameters:
WIDTH, 4, bit width of Gray input and binary output (legal range 1..16)
CHECK_STEP, 1, 1 = step_err checking enabled; 0 = step_err tied low

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, active-low, synchronous to clk
in_valid  input  1  gray is valid this cycle
in_ready  output  1  block can accept a code this cycle
gray  input  WIDTH  Gray-coded input word
out_valid  output  1  bin/step_err valid
out_ready  input  1  consumer accepts bin this cycle
bin  output  WIDTH  decoded binary word
step_err  output  1  accepted code was not a one-bit change from the previous accepted code
busy  output  1  conversion in progress (state CONV or HOLD)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- While rst_n=0 at a clk edge, the following registers clear:
  - state=IDLE, bin=0, out_valid=0, step_err=0
  - shift/index registers=0
  - prev_gray=0, prev_vld=0
- in_ready = (state==IDLE), combinational. It reads 0 whenever rst_n=0.
- State machine: IDLE, CONV, HOLD.
- IDLE:
  - Acceptance edge = in_valid && in_ready.
  - On that edge, latch gray into g_r.
  - Compute bin[WIDTH-1] = gray[WIDTH-1]; other bin bits = 0.
  - Set idx = WIDTH-2.
  - Compute step_err = CHECK_STEP && prev_vld && (popcount(gray ^ prev_gray) != 1).
  - Load prev_gray = gray, prev_vld = 1.
  - Go to CONV, or to HOLD directly if WIDTH==1.
- CONV:
  - Each edge: bin[idx] = bin[idx+1] ^ g_r[idx].
  - If idx==0, go to HOLD; otherwise idx decrements.
- HOLD:
  - out_valid=1. bin and step_err are held stable.
  - On out_valid && out_ready, clear out_valid and return to IDLE.
  - No same-cycle re-accept.
- Latency: with acceptance at edge n, out_valid is high from edge n+WIDTH-1 onward. WIDTH=4 gives 3 cycles; WIDTH=1 gives 0 extra cycles (valid right after the acceptance edge).
- Throughput: minimum WIDTH+1 cycles per code.
- Backpressure: in HOLD with out_ready=0, the block holds indefinitely. in_valid is ignored and gray is not sampled while in_ready=0.
- Identical repeated code: popcount 0, so step_err=1.
- Wrap-around (e.g. 1000 to 0000 for WIDTH=4) is a single-bit step, so step_err=0.
- First code after reset never sets step_err.
- Reset mid-operation (CONV or HOLD): the in-flight code is discarded, prev_vld is cleared, and the next accepted code is treated as first.
- busy = (state!=IDLE).

Decomposition:
- Shared package graytobin_pkg:
  - state enum (IDLE, CONV, HOLD), 2-bit encoding
  - index-width function clog2
  - Gray-to-binary reference function, for reuse by bench scoreboards
- Sub-module gray_step_chk (combinational):
  - inputs a, b (WIDTH)
  - output one_step = (a^b) has exactly one bit set
  - reusable by other Gray-pointer consumers

Test Plan:
1. Reset low 2 cycles, release; send gray=0000 with out_ready=1 -> in_ready=1 after release; out_valid 3 cycles after accept; bin=0000, step_err=0.
2. Full sweep: gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 -> bin=0..15 in order; step_err=0 every time; busy high during each conversion.
3. Non-adjacent step: accept 0001 (bin 0001), then 0110 -> bin=0100, step_err=1. Repeat 0110 -> bin=0100, step_err=1 (zero-bit change).
4. Wrap: after 1000 (bin 1111) send 0000 -> bin=0000, step_err=0.
5. Backpressure: hold out_ready=0 five cycles in HOLD while driving in_valid=1, gray=1111 -> bin stable, out_valid=1, in_ready=0, 1111 not accepted. Raise out_ready -> in_ready=1 next cycle, then 1111 accepted -> bin=1010.
6. Reset mid-CONV: assert rst_n=0 one cycle after accepting 0110 -> next cycle out_valid=0, bin=0000, busy=0. After release, send 0111 -> bin=0101, step_err=0 (prev cleared).

Source files
------------

// File: rtl/graytobin_pkg.sv
// Shared types and helpers for the bit-serial Gray-to-binary decoder.
// Holds the FSM state type, an index-width helper and a reference decode.
package graytobin_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Never returns 0 so a WIDTH=1 build still has a legal 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray_to_bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Flags whether two Gray words differ in exactly one bit position.
// Purely combinational; no latency, no flow control.
module gray_step_chk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             one_step
);

    logic [WIDTH-1:0] diff;

    assign diff = a ^ b;
    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set.
    assign one_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

endmodule

// File: rtl/graytobin_seq.sv
// Bit-serial Gray-to-binary decoder with a one-bit-step integrity flag.
// Result valid WIDTH-1 cycles after accept; holds in HOLD until out_ready, no input taken meanwhile.
module graytobin_seq
    import graytobin_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit CHECK_STEP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin,
    output logic             step_err,
    output logic             busy
);

    localparam int            IW        = clog2(WIDTH);
    localparam logic [IW-1:0] IDX_START = IW'((WIDTH >= 2) ? (WIDTH - 2) : 0);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH:0]   bin_ext;
    logic [WIDTH-1:0] prev_gray;
    logic [IW-1:0]    idx;
    logic             prev_vld;
    logic             step_err_r;
    logic             accept;
    logic             one_step;

    gray_step_chk #(.WIDTH(WIDTH)) u_step_chk (
        .a        (gray),
        .b        (prev_gray),
        .one_step (one_step)
    );

    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign bin       = bin_r;
    assign step_err  = step_err_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (WIDTH == 1) ? HOLD : CONV;
            CONV: if (idx == '0) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Resolve the bit at idx from the already-resolved bit above it.
    assign bin_ext = {1'b0, bin_r};
    always_comb begin
        bin_nxt = bin_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(idx)) bin_nxt[i] = bin_ext[i+1] ^ g_r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            g_r        <= '0;
            bin_r      <= '0;
            idx        <= '0;
            step_err_r <= 1'b0;
            prev_gray  <= '0;
            prev_vld   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                g_r        <= gray;
                bin_r      <= gray & (WIDTH'(1) << (WIDTH - 1));
                idx        <= IDX_START;
                step_err_r <= CHECK_STEP && prev_vld && !one_step;
                prev_gray  <= gray;
                prev_vld   <= 1'b1;
            end else if (state == CONV) begin
                bin_r <= bin_nxt;
                if (idx != '0) idx <= idx - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_graytobin_seq.sv
// Self-checking bench for graytobin_seq (WIDTH=4): vector table, corner sequences, random vs model.
module tb_graytobin_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bin;
    logic         step_err;
    logic         busy;

    int vectors;
    int miscompares;

    logic [W-1:0] mdl_prev;
    logic         mdl_vld;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic         e;
    } vec_t;

    vec_t         tbl[20];
    logic [W-1:0] sweep_g[16];

    graytobin_seq #(.WIDTH(W), .CHECK_STEP(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray      (gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .step_err  (step_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Binary value is the position of g in the reflected-Gray sequence.
    function automatic logic [W-1:0] model_bin(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++) begin
            if (W'(b ^ (b >> 1)) == g) return W'(b);
        end
        return '0;
    endfunction

    function automatic logic model_err(input logic [W-1:0] g);
        return mdl_vld && ($countones(g ^ mdl_prev) != 1);
    endfunction

    task automatic wait_out(input string name);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            chk({name, " busy"}, busy, 1);
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " latency"}, cyc, W - 1);
    endtask

    task automatic apply(input logic [W-1:0] g, input logic [W-1:0] eb, input logic ee, input int stall);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready before accept", in_ready, 1);
        in_valid  = 1'b1;
        gray      = g;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        gray     = W'($urandom);
        wait_out("conv");
        chk("bin", bin, eb);
        chk("step_err", step_err, ee);
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall out_valid", out_valid, 1);
            chk("stall bin", bin, eb);
            chk("stall in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post-handshake out_valid", out_valid, 0);
        chk("post-handshake in_ready", in_ready, 1);
        mdl_prev = g;
        mdl_vld  = 1'b1;
    endtask

    initial begin
        logic [W-1:0] g;
        vectors     = 0;
        miscompares = 0;
        mdl_prev    = '0;
        mdl_vld     = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        gray        = '0;

        sweep_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        for (int i = 0; i < 16; i++) tbl[i] = '{sweep_g[i], W'(i), 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0};
        tbl[17] = '{4'b0001, 4'b0001, 1'b0};
        tbl[18] = '{4'b0110, 4'b0100, 1'b1};
        tbl[19] = '{4'b0110, 4'b0100, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset bin", bin, 0);
        chk("reset step_err", step_err, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1);

        for (int i = 0; i < 20; i++) apply(tbl[i].g, tbl[i].b, tbl[i].e, i % 3);

        // Consumer stalled while a new code is offered: it must not be taken.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        gray      = 4'b0111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("bp");
        chk("bp bin", bin, 4'b0101);
        chk("bp step_err", step_err, 0);
        in_valid = 1'b1;
        gray     = 4'b1111;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp hold out_valid", out_valid, 1);
            chk("bp hold bin", bin, 4'b0101);
            chk("bp hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", in_ready, 1);
        chk("bp release out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp accepted busy", busy, 1);
        wait_out("bp2");
        chk("bp2 bin", bin, 4'b1010);
        chk("bp2 step_err", step_err, 0);
        @(posedge clk); #1;
        chk("bp2 done out_valid", out_valid, 0);
        mdl_prev = 4'b1111;
        mdl_vld  = 1'b1;

        // Reset one cycle into a conversion discards it and forgets the previous code.
        in_valid = 1'b1;
        gray     = 4'b0110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midrst pre busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst bin", bin, 0);
        chk("midrst busy", busy, 0);
        chk("midrst in_ready", in_ready, 0);
        rst_n   = 1'b1;
        mdl_vld = 1'b0;
        apply(4'b0111, 4'b0101, 1'b0, 1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 1) g = mdl_prev ^ W'(1 << $urandom_range(W - 1, 0));
            else g = W'($urandom);
            apply(g, model_bin(g), model_err(g), $urandom_range(3, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
